// File: rtl/jt7759_pkg.sv
// Shared definitions for the jt7759 ADPCM ROM line cache: FSM states,
// default geometry and the line-address type.
package jt7759_pkg;

  localparam int unsigned JT7759_AW = 17;
  localparam int unsigned JT7759_LW = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_PREFETCH = 2'd2
  } state_t;

  typedef logic [JT7759_AW-JT7759_LW-1:0] line_addr_t;

endpackage

// File: rtl/jt7759_romcache_slot.sv
// One cache line slot: line data, tag and valid bit, with lookup against the
// current line and the next sequential line, plus byte selection.
module jt7759_romcache_slot
  import jt7759_pkg::*;
#(
  parameter int unsigned AW = JT7759_AW,
  parameter int unsigned LW = JT7759_LW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_clr,
  input  logic                 i_wr,
  input  logic [AW-LW-1:0]     i_wr_tag,
  input  logic [(8<<LW)-1:0]   i_wr_data,
  input  logic [AW-LW-1:0]     i_tag,
  input  logic [AW-LW-1:0]     i_tag_nxt,
  input  logic [LW-1:0]        i_sel,
  output logic                 o_hit,
  output logic                 o_hit_nxt,
  output logic [7:0]           o_byte
);

  logic                 r_valid;
  logic [AW-LW-1:0]     r_tag;
  logic [(8<<LW)-1:0]   r_data;

  // Invalidation takes priority over a fill landing in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_wr) begin
      r_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr) begin
      r_tag  <= i_wr_tag;
      r_data <= i_wr_data;
    end
  end

  assign o_hit     = r_valid && (r_tag == i_tag);
  assign o_hit_nxt = r_valid && (r_tag == i_tag_nxt);
  assign o_byte    = r_data[{i_sel, 3'b000} +: 8];

endmodule

// File: rtl/jt7759_romcache.sv
// Two-line read cache between the jt7759 ADPCM engine and an SDRAM arbiter,
// with demand fetch on miss and sequential prefetch of the following line.
module jt7759_romcache
  import jt7759_pkg::*;
#(
  parameter int unsigned AW = JT7759_AW,
  parameter int unsigned LW = JT7759_LW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 rom_cs,
  input  logic [AW-1:0]        rom_addr,
  output logic [7:0]           rom_data,
  output logic                 rom_ok,
  output logic                 mem_req,
  output logic [AW-LW-1:0]     mem_addr,
  input  logic [(8<<LW)-1:0]   mem_data,
  input  logic                 mem_ack
);

  localparam int unsigned TW = AW - LW;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_mem_req;
  logic [TW-1:0]   r_mem_addr;
  logic            r_tgt;
  logic            r_discard;
  logic            r_last_slot;
  logic            r_prev_hit;
  logic [AW-1:0]   r_prev_addr;
  logic [7:0]      r_rom_data;

  logic [TW-1:0]   w_line;
  logic [TW-1:0]   w_line_nxt;
  logic [1:0]      w_slot_hit;
  logic [1:0]      w_slot_hit_nxt;
  logic [1:0]      w_slot_wr;
  logic [7:0]      w_byte [2];
  logic            w_hit;
  logic            w_miss;
  logic            w_hit_slot;
  logic            w_fill;
  logic            w_start;
  logic [TW-1:0]   w_start_addr;
  logic            w_start_tgt;

  assign w_line     = rom_addr[AW-1:LW];
  assign w_line_nxt = w_line + TW'(1);

  for (genvar g = 0; g < 2; g++) begin : g_slot
    jt7759_romcache_slot #(
      .AW (AW),
      .LW (LW)
    ) u_slot (
      .clk       (clk),
      .rstn      (rstn),
      .i_clr     (flush),
      .i_wr      (w_slot_wr[g]),
      .i_wr_tag  (r_mem_addr),
      .i_wr_data (mem_data),
      .i_tag     (w_line),
      .i_tag_nxt (w_line_nxt),
      .i_sel     (rom_addr[LW-1:0]),
      .o_hit     (w_slot_hit[g]),
      .o_hit_nxt (w_slot_hit_nxt[g]),
      .o_byte    (w_byte[g])
    );
  end

  // A flush cycle never counts as a hit, so stale data cannot raise rom_ok.
  assign w_hit      = rom_cs && !flush && (w_slot_hit != 2'b00);
  assign w_miss     = rom_cs && !flush && (w_slot_hit == 2'b00);
  assign w_hit_slot = w_slot_hit[0] ? 1'b0 : 1'b1;
  assign w_fill     = r_mem_req && mem_ack && !flush && !r_discard;
  assign w_slot_wr  = w_fill ? (r_tgt ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_start_addr = w_line;
    w_start_tgt  = !r_last_slot;
    case (r_state)
      ST_IDLE: begin
        if (w_miss) begin
          w_state_nxt = ST_FETCH;
          w_start     = 1'b1;
        end else if (w_hit && (w_slot_hit_nxt == 2'b00)) begin
          w_state_nxt  = ST_PREFETCH;
          w_start      = 1'b1;
          w_start_addr = w_line_nxt;
          w_start_tgt  = !w_hit_slot;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH, ST_PREFETCH: begin
        if (mem_ack) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A flush seen while a request is outstanding poisons that fill.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= {TW{1'b0}};
      r_tgt      <= 1'b0;
      r_discard  <= 1'b0;
    end else begin
      r_mem_req <= (w_state_nxt != ST_IDLE);
      if (w_start) begin
        r_mem_addr <= w_start_addr;
        r_tgt      <= w_start_tgt;
      end
      if (w_start || (r_mem_req && mem_ack)) begin
        r_discard <= 1'b0;
      end else if (flush && r_mem_req) begin
        r_discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prev_hit  <= 1'b0;
      r_prev_addr <= {AW{1'b0}};
      r_last_slot <= 1'b0;
      r_rom_data  <= 8'h00;
    end else begin
      r_prev_hit  <= w_hit;
      r_prev_addr <= rom_addr;
      if (w_hit) begin
        r_last_slot <= w_hit_slot;
        r_rom_data  <= w_byte[w_hit_slot];
      end
    end
  end

  assign rom_ok   = rom_cs && !flush && r_prev_hit && (rom_addr == r_prev_addr);
  assign rom_data = r_rom_data;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_jt7759_romcache.sv
// Directed bench for jt7759_romcache with a behavioural SDRAM responder.
module tb_jt7759_romcache;
  import jt7759_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        rom_cs;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;

  int         ack_lat   = 3;
  bit         auto_ack  = 1'b1;
  bit         stray_ack = 1'b0;
  bit         req_prev  = 1'b0;
  int         rsp_cnt   = 0;
  line_addr_t req_log[$];

  always #5 clk = ~clk;

  jt7759_romcache #(.AW(17), .LW(2)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_ack  (mem_ack)
  );

  function automatic logic [7:0] rom_byte(input logic [16:0] a);
    return {a[4:0], a[7:5]} ^ a[15:8] ^ {7'd0, a[16]} ^ 8'hA5;
  endfunction

  function automatic logic [31:0] line_word(input line_addr_t l);
    logic [16:0] b;
    b = {l, 2'b00};
    return {rom_byte(b + 17'd3), rom_byte(b + 17'd2), rom_byte(b + 17'd1), rom_byte(b)};
  endfunction

  // SDRAM side: acks ack_lat cycles after the request rises, logs every request.
  initial begin
    mem_ack  = 1'b0;
    mem_data = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (stray_ack) begin
        mem_ack   = 1'b1;
        mem_data  = 32'hDEADBEEF;
        stray_ack = 1'b0;
      end else if (mem_req && auto_ack) begin
        if (rsp_cnt == ack_lat - 1) begin
          mem_ack  = 1'b1;
          mem_data = line_word(mem_addr);
          rsp_cnt  = 0;
        end else begin
          rsp_cnt++;
        end
      end else begin
        rsp_cnt = 0;
      end
      if (mem_req && !req_prev) req_log.push_back(mem_addr);
      req_prev = mem_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ok(input int max_cyc, output int n, output bit to);
    n  = 0;
    to = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      n++;
      if (rom_ok) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_req(output bit to);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_flush();
    rom_cs = 1'b0;
    flush  = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    cyc(12);
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; rom_cs = 1'b0; rom_addr = 17'h0;
    cyc(2);
    total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %0b expected 0", mem_req); end
    total++;
    if (mem_addr !== 15'h0) begin bad++; $display("FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
    total++;
    if (rom_ok !== 1'b0) begin bad++; $display("FAIL reset_rom_ok: got %0b expected 0", rom_ok); end
    total++;
    if (rom_data !== 8'h00) begin bad++; $display("FAIL reset_rom_data: got %0h expected 0", rom_data); end
    rstn = 1'b1;
    cyc(1);
  endtask

  task automatic test_cold_miss();
    int n; bit to; int base;
    ack_lat = 6;
    base = req_log.size();
    rom_cs = 1'b1; rom_addr = 17'h00005;
    wait_ok(40, n, to);
    total++;
    if (to || n != 8) begin bad++; $display("FAIL cold_latency: got %0d cycles (timeout=%0b) expected 8", n, to); end
    total++;
    if (rom_data !== rom_byte(17'h00005)) begin bad++; $display("FAIL cold_data: got %0h expected %0h", rom_data, rom_byte(17'h00005)); end
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 15'h0002) begin bad++; $display("FAIL cold_prefetch: got req=%0b addr=%0h expected req=1 addr=2", mem_req, mem_addr); end
    cyc(8);
    total++;
    if (req_log.size() != base + 2 || req_log[base] !== 15'h0001 || req_log[base+1] !== 15'h0002) begin
      bad++; $display("FAIL cold_req_log: got %0d reqs first=%0h second=%0h expected 2 reqs 1,2", req_log.size() - base, req_log[base], req_log[base+1]);
    end
  endtask

  task automatic test_stream();
    int n; bit to; int base; int exp_n;
    ack_lat = 3;
    do_flush();
    base = req_log.size();
    for (int a = 0; a < 32; a++) begin
      rom_cs = 1'b1; rom_addr = 17'(a);
      exp_n = (a == 0) ? 5 : 1;
      wait_ok(40, n, to);
      total++;
      if (to || n != exp_n || rom_data !== rom_byte(17'(a))) begin
        bad++; $display("FAIL stream_%0h: got %0d cycles data %0h expected %0d cycles data %0h", a, n, rom_data, exp_n, rom_byte(17'(a)));
      end
      cyc(3);
    end
    total++;
    if (req_log.size() != base + 9) begin bad++; $display("FAIL stream_req_count: got %0d expected 9", req_log.size() - base); end
  endtask

  task automatic test_wrap();
    int n; bit to; int base; int exp_n;
    logic [16:0] a;
    ack_lat = 3;
    do_flush();
    base = req_log.size();
    for (int i = 0; i < 4; i++) begin
      a = 17'h1FFFC + 17'(i);
      rom_cs = 1'b1; rom_addr = a;
      exp_n = (i == 0) ? 5 : 1;
      wait_ok(40, n, to);
      total++;
      if (to || n != exp_n || rom_data !== rom_byte(a)) begin
        bad++; $display("FAIL wrap_%0h: got %0d cycles data %0h expected %0d cycles data %0h", a, n, rom_data, exp_n, rom_byte(a));
      end
      cyc(3);
    end
    total++;
    if (req_log.size() != base + 2 || req_log[base] !== 15'h7FFF || req_log[base+1] !== 15'h0000) begin
      bad++; $display("FAIL wrap_prefetch: got %0d reqs %0h,%0h expected 7fff,0", req_log.size() - base, req_log[base], req_log[base+1]);
    end
    rom_addr = 17'h00000;
    wait_ok(40, n, to);
    total++;
    if (to || n != 1 || rom_data !== rom_byte(17'h0)) begin
      bad++; $display("FAIL wrap_zero_hit: got %0d cycles data %0h expected 1 cycle data %0h", n, rom_data, rom_byte(17'h0));
    end
  endtask

  task automatic test_flush();
    int n; bit to; int base; bit seen_ok;
    // Flush while the demand fetch is in flight.
    ack_lat = 6;
    do_flush();
    base = req_log.size();
    rom_cs = 1'b1; rom_addr = 17'h00040;
    wait_req(to);
    total++;
    if (to) begin bad++; $display("FAIL flight_req: got no request expected mem_req=1"); end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen_ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rom_ok) seen_ok = 1'b1;
      if (req_log.size() >= base + 2) break;
    end
    total++;
    if (seen_ok || req_log.size() != base + 2 || req_log[base+1] !== 15'h0010) begin
      bad++; $display("FAIL flight_refetch: got rom_ok_seen=%0b reqs=%0d addr=%0h expected 0,2,10", seen_ok, req_log.size() - base, req_log[base+1]);
    end
    wait_ok(40, n, to);
    total++;
    if (to || rom_data !== rom_byte(17'h00040)) begin bad++; $display("FAIL flight_data: got %0h expected %0h", rom_data, rom_byte(17'h00040)); end
    // Flush on a steady hit drops rom_ok in the same cycle.
    base = req_log.size();
    flush = 1'b1;
    #1;
    total++;
    if (rom_ok !== 1'b0) begin bad++; $display("FAIL flush_rom_ok: got %0b expected 0", rom_ok); end
    @(negedge clk);
    flush = 1'b0;
    wait_ok(40, n, to);
    total++;
    if (to || req_log.size() <= base || req_log[base] !== 15'h0010 || rom_data !== rom_byte(17'h00040)) begin
      bad++; $display("FAIL flush_refill: got reqs=%0d data=%0h expected refetch of 10 data %0h", req_log.size() - base, rom_data, rom_byte(17'h00040));
    end
    // Flush coinciding with mem_ack: the slot stays invalid.
    ack_lat = 3;
    do_flush();
    base = req_log.size();
    rom_cs = 1'b1; rom_addr = 17'h00040;
    wait_req(to);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen_ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rom_ok) seen_ok = 1'b1;
      if (req_log.size() >= base + 2) break;
      @(negedge clk);
    end
    total++;
    if (to || seen_ok || req_log.size() != base + 2 || req_log[base+1] !== 15'h0010) begin
      bad++; $display("FAIL flush_ack_same: got rom_ok_seen=%0b reqs=%0d expected 0,2", seen_ok, req_log.size() - base);
    end
    cyc(10);
  endtask

  task automatic test_addr_change();
    int n; bit to;
    ack_lat = 3;
    do_flush();
    rom_cs = 1'b1; rom_addr = 17'h00004;
    wait_ok(40, n, to);
    cyc(8);
    total++;
    if (to || rom_ok !== 1'b1 || rom_data !== rom_byte(17'h00004)) begin
      bad++; $display("FAIL chg_before: got ok=%0b data=%0h expected 1 %0h", rom_ok, rom_data, rom_byte(17'h00004));
    end
    rom_addr = 17'h00008;
    #1;
    total++;
    if (rom_ok !== 1'b0) begin bad++; $display("FAIL chg_gap: got %0b expected 0", rom_ok); end
    @(negedge clk);
    total++;
    if (rom_ok !== 1'b1 || rom_data !== rom_byte(17'h00008)) begin
      bad++; $display("FAIL chg_after: got ok=%0b data=%0h expected 1 %0h", rom_ok, rom_data, rom_byte(17'h00008));
    end
    cyc(8);
  endtask

  task automatic test_cs_drop();
    int n; bit to; int base;
    ack_lat = 6;
    do_flush();
    base = req_log.size();
    rom_cs = 1'b1; rom_addr = 17'h00200;
    wait_req(to);
    @(negedge clk);
    rom_cs = 1'b0;
    cyc(10);
    total++;
    if (to || mem_req !== 1'b0 || req_log.size() != base + 1) begin
      bad++; $display("FAIL csdrop_reqs: got req=%0b reqs=%0d expected 0,1", mem_req, req_log.size() - base);
    end
    rom_cs = 1'b1; rom_addr = 17'h00201;
    wait_ok(40, n, to);
    total++;
    if (to || n != 1 || rom_data !== rom_byte(17'h00201)) begin
      bad++; $display("FAIL csdrop_hit: got %0d cycles data %0h expected 1 cycle %0h", n, rom_data, rom_byte(17'h00201));
    end
    cyc(10);
  endtask

  task automatic test_reset_mid_fetch();
    int n; bit to; int base;
    do_flush();
    auto_ack = 1'b0;
    base = req_log.size();
    rom_cs = 1'b1; rom_addr = 17'h00100;
    wait_req(to);
    rstn = 1'b0; rom_cs = 1'b0;
    #1;
    total++;
    if (to || mem_req !== 1'b0 || mem_addr !== 15'h0 || rom_ok !== 1'b0) begin
      bad++; $display("FAIL rst_mid: got req=%0b addr=%0h ok=%0b expected 0,0,0", mem_req, mem_addr, rom_ok);
    end
    @(negedge clk);
    rstn = 1'b1;
    stray_ack = 1'b1;
    cyc(4);
    total++;
    if (mem_req !== 1'b0 || req_log.size() != base + 1) begin
      bad++; $display("FAIL rst_stray_ack: got req=%0b reqs=%0d expected 0,1", mem_req, req_log.size() - base);
    end
    auto_ack = 1'b1; ack_lat = 3;
    rom_cs = 1'b1; rom_addr = 17'h00100;
    wait_ok(40, n, to);
    total++;
    if (to || n != 5 || rom_data !== rom_byte(17'h00100) || req_log.size() < base + 2 || req_log[base+1] !== 15'h0040) begin
      bad++; $display("FAIL rst_refetch: got %0d cycles data %0h reqs=%0d expected 5 cycles %0h refetch of 40", n, rom_data, req_log.size() - base, rom_byte(17'h00100));
    end
    cyc(8);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_stream();
    test_wrap();
    test_flush();
    test_addr_change();
    test_cs_drop();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
